// File: rtl/trap_sequencer.sv
// Machine external interrupt trap sequencer: latches interrupt edges, arbitrates by
// lowest index, and drives the flush / CSR-write / redirect sequence for entry and mret.
module trap_sequencer #(
    parameter int P_NIRQ = 6,
    parameter int P_ID_W = 3
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic [P_NIRQ-1:0] i_MEI,
    input  logic [P_NIRQ-1:0] i_MIE,
    input  logic [31:0]       i_MTVEC,
    input  logic              i_BOUNDARY,
    input  logic [31:0]       i_PC,
    input  logic [31:0]       i_INSTR,
    input  logic              i_MRET,
    output logic              o_FLUSH,
    output logic              o_PC_LOAD,
    output logic [31:0]       o_PC_TARGET,
    output logic              o_TRAP_WE,
    output logic [31:0]       o_MEPC,
    output logic [31:0]       o_MTVAL,
    output logic [31:0]       o_MCAUSE,
    output logic              o_IN_TRAP,
    output logic [P_NIRQ-1:0] o_PENDING
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_FLUSH, S_ENTER, S_HANDLER, S_RETURN
    } state_t;

    state_t              state_q;
    logic [P_NIRQ-1:0]   mei_q;
    logic                armed_q;
    logic [P_NIRQ-1:0]   pending_q, pending_d;
    logic [P_ID_W-1:0]   id_q;
    logic [31:0]         mepc_q, mtval_q, mcause_q;
    logic                flush_q, we_q, load_q, in_trap_q;
    logic [31:0]         tgt_q;

    logic [P_NIRQ-1:0]   rise, eligible, clr;
    logic [P_ID_W-1:0]   sel_id;
    logic [31:0]         base, vec_tgt;

    function automatic logic [P_ID_W-1:0] lowest_id(input logic [P_NIRQ-1:0] v);
        lowest_id = '0;
        for (int k = P_NIRQ - 1; k >= 0; k--)
            if (v[k]) lowest_id = P_ID_W'(k);
    endfunction

    // armed_q masks the first post-reset cycle so lines held high through reset are not edges
    always_comb begin
        rise      = armed_q ? (i_MEI & ~mei_q) : '0;
        eligible  = pending_q & i_MIE;
        sel_id    = lowest_id(eligible);
        clr       = (state_q == S_FLUSH) ? ({{(P_NIRQ-1){1'b0}}, 1'b1} << id_q) : '0;
        pending_d = (pending_q & ~clr) | rise;
        base      = {i_MTVEC[31:2], 2'b00};
        vec_tgt   = (i_MTVEC[1:0] == 2'b01)
                    ? base + {{(30-P_ID_W){1'b0}}, id_q, 2'b00}
                    : base;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q   <= S_IDLE;
            mei_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            id_q      <= '0;
            mepc_q    <= '0;
            mtval_q   <= '0;
            mcause_q  <= '0;
            flush_q   <= 1'b0;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            tgt_q     <= '0;
            in_trap_q <= 1'b0;
        end else begin
            mei_q     <= i_MEI;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            flush_q   <= 1'b0;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            tgt_q     <= '0;
            in_trap_q <= 1'b0;
            // Output registers are loaded with the values belonging to the state being entered
            case (state_q)
                S_IDLE: begin
                    if (|eligible) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!(|eligible)) begin
                        state_q <= S_IDLE;
                    end else begin
                        id_q <= sel_id;
                        if (i_BOUNDARY) begin
                            mepc_q   <= i_PC;
                            mtval_q  <= i_INSTR;
                            mcause_q <= 32'h8000_0000 | (32'd1 << sel_id);
                            flush_q  <= 1'b1;
                            we_q     <= 1'b1;
                            state_q  <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    load_q  <= 1'b1;
                    tgt_q   <= vec_tgt;
                    state_q <= S_ENTER;
                end
                S_ENTER: begin
                    in_trap_q <= 1'b1;
                    state_q   <= S_HANDLER;
                end
                S_HANDLER: begin
                    if (i_MRET) begin
                        flush_q <= 1'b1;
                        load_q  <= 1'b1;
                        tgt_q   <= mepc_q;
                        state_q <= S_RETURN;
                    end else begin
                        in_trap_q <= 1'b1;
                    end
                end
                S_RETURN: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_FLUSH     = flush_q;
    assign o_TRAP_WE   = we_q;
    assign o_PC_LOAD   = load_q;
    assign o_PC_TARGET = tgt_q;
    assign o_IN_TRAP   = in_trap_q;
    assign o_MEPC      = mepc_q;
    assign o_MTVAL     = mtval_q;
    assign o_MCAUSE    = mcause_q;
    assign o_PENDING   = pending_q;

endmodule
